// File: rtl/ltc2333_read_if.sv
// AXI-Stream beat bundle for the LTC2333 capture path.
// master drives data/valid/last; slave returns ready.
interface ltc2333_read_if;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (output m_axis_tdata, output m_axis_tvalid, output m_axis_tlast,
                  input  m_axis_tready);
  modport slave  (input  m_axis_tdata, input  m_axis_tvalid, input  m_axis_tlast,
                  output m_axis_tready);
endinterface

// File: rtl/ltc2333_read.sv
// LTC2333 readout capture: synchronizes scko/sdo per lane, deserializes 24-bit words,
// buffers them per lane and streams tagged beats in interleaved lane order.
//
// state   | meaning
// IDLE    | waiting for frame_start, scko edges ignored
// CAPTURE | lanes shifting in words, beats streamed as they become available
// DRAIN   | all words captured, emitting the remaining beats
module ltc2333_read #(
  parameter int N_LANES     = 2,
  parameter int WORD_BITS   = 24,
  parameter int MAX_WORDS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [3:0]         n_words,
  input  logic [N_LANES-1:0] scko,
  input  logic [N_LANES-1:0] sdo,
  input  logic               clear_status,
  ltc2333_read_if.master     axis,
  output logic               busy,
  output logic               frame_done,
  output logic               extra_edge_err,
  output logic               start_err
);
  localparam int WIDX_W = $clog2(MAX_WORDS);
  localparam int WCNT_W = WIDX_W + 1;
  localparam int BIT_W  = $clog2(WORD_BITS);
  localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][N_LANES-1:0] scko_pipe, sdo_pipe;
  logic [N_LANES-1:0] scko_prev, scko_s, sdo_s, edge_det;
  logic [N_LANES-1:0] lane_done, cap_edge, extra_edge;

  logic [WORD_BITS-1:0] shift_q   [N_LANES];
  logic [WORD_BITS-1:0] wr_data_q [N_LANES];
  logic [BIT_W-1:0]     bit_cnt_q [N_LANES];
  logic [WCNT_W-1:0]    word_cnt_q[N_LANES];
  logic [N_LANES-1:0]   wr_pend_q;
  logic [WORD_BITS-1:0] buf_mem   [N_LANES][MAX_WORDS];

  logic [WCNT_W-1:0] n_q, n_eff;
  logic [3:0]        frame_cnt_q;
  logic [LANE_W-1:0] rd_lane_q;
  logic [WIDX_W-1:0] rd_word_q;
  logic              issued_all_q;
  logic              tvalid_q, tlast_q;
  logic [31:0]       tdata_q;

  logic                 start_frame, all_done, avail_buf, avail_byp, load, rd_last;
  logic [WORD_BITS-1:0] rd_data;

  assign scko_s      = scko_pipe[SYNC_STAGES-1];
  assign sdo_s       = sdo_pipe[SYNC_STAGES-1];
  assign edge_det    = scko_s & ~scko_prev;
  assign start_frame = frame_start && (state_q == IDLE);

  always_comb begin
    lane_done  = '0;
    cap_edge   = '0;
    extra_edge = '0;
    for (int l = 0; l < N_LANES; l++) begin
      lane_done[l]  = (word_cnt_q[l] == n_q);
      cap_edge[l]   = edge_det[l] && (state_q != IDLE) && !lane_done[l];
      extra_edge[l] = edge_det[l] && (state_q != IDLE) && lane_done[l];
    end
  end
  assign all_done = &lane_done;

  always_comb begin
    n_eff = WCNT_W'(n_words);
    if (n_words == 4'd0 || 32'(n_words) > MAX_WORDS) n_eff = WCNT_W'(MAX_WORDS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scko_pipe <= '0;
      sdo_pipe  <= '0;
      scko_prev <= '0;
    end else begin
      scko_pipe <= {scko_pipe[SYNC_STAGES-2:0], scko};
      sdo_pipe  <= {sdo_pipe[SYNC_STAGES-2:0], sdo};
      scko_prev <= scko_s;
    end
  end

  // Completed word is latched on its last edge and committed to the buffer one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend_q <= '0;
      for (int l = 0; l < N_LANES; l++) begin
        shift_q[l]    <= '0;
        wr_data_q[l]  <= '0;
        bit_cnt_q[l]  <= '0;
        word_cnt_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < N_LANES; l++) begin
        if (start_frame) begin
          bit_cnt_q[l]  <= '0;
          word_cnt_q[l] <= '0;
          wr_pend_q[l]  <= 1'b0;
        end else begin
          wr_pend_q[l] <= 1'b0;
          if (wr_pend_q[l]) word_cnt_q[l] <= word_cnt_q[l] + WCNT_W'(1);
          if (cap_edge[l]) begin
            shift_q[l] <= {shift_q[l][WORD_BITS-2:0], sdo_s[l]};
            if (bit_cnt_q[l] == BIT_W'(WORD_BITS-1)) begin
              bit_cnt_q[l] <= '0;
              wr_pend_q[l] <= 1'b1;
              wr_data_q[l] <= {shift_q[l][WORD_BITS-2:0], sdo_s[l]};
            end else begin
              bit_cnt_q[l] <= bit_cnt_q[l] + BIT_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < N_LANES; l++)
      if (wr_pend_q[l]) buf_mem[l][word_cnt_q[l][WIDX_W-1:0]] <= wr_data_q[l];
  end

  // A word being committed this cycle is forwarded so the beat appears the next cycle.
  assign avail_buf = word_cnt_q[rd_lane_q] > {1'b0, rd_word_q};
  assign avail_byp = wr_pend_q[rd_lane_q] && (word_cnt_q[rd_lane_q] == {1'b0, rd_word_q});
  assign rd_data   = avail_buf ? buf_mem[rd_lane_q][rd_word_q] : wr_data_q[rd_lane_q];
  assign rd_last   = (rd_lane_q == LANE_W'(N_LANES-1)) && ({1'b0, rd_word_q} == n_q - WCNT_W'(1));
  assign load      = (state_q != IDLE) && !issued_all_q && (avail_buf || avail_byp) &&
                     (!tvalid_q || axis.m_axis_tready);
  assign frame_done = tvalid_q && axis.m_axis_tready && tlast_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q          <= '0;
      frame_cnt_q  <= '0;
      rd_lane_q    <= '0;
      rd_word_q    <= '0;
      issued_all_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
    end else begin
      if (start_frame) begin
        n_q          <= n_eff;
        rd_lane_q    <= '0;
        rd_word_q    <= '0;
        issued_all_q <= 1'b0;
      end else if (load) begin
        if (rd_last) issued_all_q <= 1'b1;
        if (rd_lane_q == LANE_W'(N_LANES-1)) begin
          rd_lane_q <= '0;
          rd_word_q <= rd_word_q + WIDX_W'(1);
        end else begin
          rd_lane_q <= rd_lane_q + LANE_W'(1);
        end
      end
      if (load) begin
        tvalid_q <= 1'b1;
        tlast_q  <= rd_last;
        tdata_q  <= {frame_cnt_q, rd_lane_q, rd_word_q, rd_data};
      end else if (axis.m_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      if (frame_done) frame_cnt_q <= frame_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      extra_edge_err <= 1'b0;
      start_err      <= 1'b0;
    end else begin
      state_q        <= state_d;
      extra_edge_err <= (|extra_edge) || (extra_edge_err && !clear_status);
      start_err      <= (frame_start && state_q != IDLE) || (start_err && !clear_status);
    end
  end

  // The final handshake can land while still in CAPTURE when the last word is forwarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = CAPTURE;
      CAPTURE: if (frame_done) state_d = IDLE;
               else if (all_done) state_d = DRAIN;
      DRAIN:   if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy               = (state_q != IDLE);
  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tdata  = tdata_q;
  assign axis.m_axis_tlast  = tlast_q;
endmodule

// File: tb/tb_ltc2333_read.sv
// Directed bench for ltc2333_read: bit-bangs scko/sdo per lane and checks the beat stream.
module tb_ltc2333_read;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] n_words = 4'd0;
  logic [1:0] scko = 2'b00;
  logic [1:0] sdo = 2'b00;
  logic       clear_status = 1'b0;
  logic       busy, frame_done, extra_edge_err, start_err;

  ltc2333_read_if axis ();

  ltc2333_read dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .n_words(n_words),
    .scko(scko), .sdo(sdo), .clear_status(clear_status), .axis(axis),
    .busy(busy), .frame_done(frame_done), .extra_edge_err(extra_edge_err),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  logic [31:0] beat_q[$];
  logic        last_q[$];
  int          cyc_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (axis.m_axis_tvalid && axis.m_axis_tready) begin
      beat_q.push_back(axis.m_axis_tdata);
      last_q.push_back(axis.m_axis_tlast);
      cyc_q.push_back(cyc);
    end
  end

  task automatic clear_log();
    beat_q.delete(); last_q.delete(); cyc_q.delete();
  endtask

  task automatic pulse_start(input logic [3:0] n);
    @(posedge clk); #1; n_words = n; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clear_status = 1'b1;
    @(posedge clk); #1; clear_status = 1'b0;
  endtask

  // Shifts bits [23-first .. 23-first-count+1] of d0/d1, MSB first, on lanes enabled by mask.
  task automatic send_bits(input logic [23:0] d0, input logic [23:0] d1,
                           input int first, input int count, input logic [1:0] mask);
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1; scko = 2'b00; sdo = {d1[23-first-i], d0[23-first-i]};
      repeat (2) @(posedge clk); #1; scko = mask;
      repeat (2) @(posedge clk);
    end
    @(posedge clk); #1; scko = 2'b00;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    axis.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    total++; if (axis.m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", axis.m_axis_tvalid); else passed++;
    total++; if (axis.m_axis_tdata !== 32'h0) $display("FAIL rst_tdata: got %h want 0", axis.m_axis_tdata); else passed++;
    total++; if (axis.m_axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", axis.m_axis_tlast); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if ({frame_done, extra_edge_err, start_err} !== 3'b000)
      $display("FAIL rst_flags: got %b want 000", {frame_done, extra_edge_err, start_err}); else passed++;
  endtask

  task automatic test_single();
    bit ok;
    int dn = 0;
    clear_log();
    pulse_start(4'd1);
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
    send_bits(24'hABCDE5, 24'h123456, 0, 24, 2'b11);
    wait_frame(ok);
    total++; if (!ok) $display("FAIL single_timeout: got no frame_done want frame_done"); else passed++;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (frame_done) dn++; end
    total++; if (beat_q.size() !== 2) $display("FAIL single_count: got %0d want 2", beat_q.size()); else passed++;
    total++; if (beat_q[0] !== 32'h00ABCDE5 || last_q[0] !== 1'b0)
      $display("FAIL single_beat0: got %h/%b want 00abcde5/0", beat_q[0], last_q[0]); else passed++;
    total++; if (beat_q[1] !== 32'h08123456 || last_q[1] !== 1'b1)
      $display("FAIL single_beat1: got %h/%b want 08123456/1", beat_q[1], last_q[1]); else passed++;
    total++; if (dn !== 0) $display("FAIL single_done_once: got %0d extra pulses want 0", dn); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_full();
    bit ok;
    logic [31:0] exp;
    logic [23:0] w;
    logic [2:0]  k;
    logic        ln;
    clear_log();
    pulse_start(4'd0);
    for (int i = 0; i < 8; i++) send_bits(24'(i), 24'h100000 + 24'(i), 0, 24, 2'b11);
    wait_frame(ok);
    repeat (2) @(negedge clk);
    total++; if (!ok) $display("FAIL full_timeout: got no frame_done want frame_done"); else passed++;
    total++; if (beat_q.size() !== 16) $display("FAIL full_count: got %0d want 16", beat_q.size()); else passed++;
    for (int j = 0; j < 16; j++) begin
      ln = 1'(j % 2); k = 3'(j / 2);
      w = ln ? 24'h100000 + 24'(k) : 24'(k);
      exp = {4'd1, ln, k, w};
      total++; if (beat_q[j] !== exp || last_q[j] !== (j == 15))
        $display("FAIL full_beat%0d: got %h/%b want %h/%b", j, beat_q[j], last_q[j], exp, j == 15); else passed++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] held, exp;
    logic [2:0]  k;
    logic        ln;
    clear_log();
    axis.m_axis_tready = 1'b0;
    pulse_start(4'd0);
    for (int i = 0; i < 8; i++) send_bits(24'hA00000 + 24'(i), 24'hB00000 + 24'(i), 0, 24, 2'b11);
    repeat (10) @(negedge clk);
    held = axis.m_axis_tdata;
    total++; if (axis.m_axis_tvalid !== 1'b1 || held !== 32'h20A00000)
      $display("FAIL stall_first: got %b/%h want 1/20a00000", axis.m_axis_tvalid, held); else passed++;
    repeat (5) @(negedge clk);
    total++; if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== 32'h20A00000)
      $display("FAIL stall_hold: got %b/%h want 1/20a00000", axis.m_axis_tvalid, axis.m_axis_tdata); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b want 1", busy); else passed++;
    @(posedge clk); #1; axis.m_axis_tready = 1'b1;
    wait_frame(ok);
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL stall_busy_fall: got %b want 0", busy); else passed++;
    total++; if (!ok || beat_q.size() !== 16) $display("FAIL stall_count: got %0d want 16", beat_q.size()); else passed++;
    total++; if (cyc_q[15] - cyc_q[0] !== 15) $display("FAIL stall_rate: got span %0d want 15", cyc_q[15] - cyc_q[0]); else passed++;
    for (int j = 0; j < 16; j++) begin
      ln = 1'(j % 2); k = 3'(j / 2);
      exp = {4'd2, ln, k, (ln ? 24'hB00000 : 24'hA00000) + 24'(k)};
      total++; if (beat_q[j] !== exp) $display("FAIL stall_beat%0d: got %h want %h", j, beat_q[j], exp); else passed++;
    end
  endtask

  task automatic test_extra_edge();
    bit ok;
    clear_log();
    pulse_start(4'd1);
    send_bits(24'hABCDE5, 24'h0, 0, 24, 2'b01);
    send_bits(24'h800000, 24'h0, 0, 1, 2'b01);
    repeat (2) @(negedge clk);
    total++; if (extra_edge_err !== 1'b1) $display("FAIL extra_set: got %b want 1", extra_edge_err); else passed++;
    pulse_clear();
    @(negedge clk);
    total++; if (extra_edge_err !== 1'b0) $display("FAIL extra_clear: got %b want 0", extra_edge_err); else passed++;
    // 26th edge: the detect cycle is two clocks after scko rises through the synchronizer
    @(posedge clk); #1; scko = 2'b00; sdo = 2'b01;
    repeat (2) @(posedge clk); #1; scko = 2'b01;
    repeat (2) @(posedge clk); #1; clear_status = 1'b1;
    @(posedge clk); #1; clear_status = 1'b0;
    @(negedge clk);
    total++; if (extra_edge_err !== 1'b1) $display("FAIL extra_set_wins: got %b want 1", extra_edge_err); else passed++;
    @(posedge clk); #1; scko = 2'b00;
    send_bits(24'h0, 24'h123456, 0, 24, 2'b10);
    wait_frame(ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || beat_q.size() !== 2) $display("FAIL extra_count: got %0d want 2", beat_q.size()); else passed++;
    total++; if (beat_q[0] !== 32'h30ABCDE5) $display("FAIL extra_data0: got %h want 30abcde5", beat_q[0]); else passed++;
    total++; if (beat_q[1] !== 32'h38123456) $display("FAIL extra_data1: got %h want 38123456", beat_q[1]); else passed++;
    pulse_clear();
  endtask

  task automatic test_start_err();
    bit ok;
    clear_log();
    pulse_start(4'd1);
    send_bits(24'h5A5A5A, 24'h0F0F0F, 0, 10, 2'b11);
    pulse_start(4'd3);
    @(negedge clk);
    total++; if (start_err !== 1'b1) $display("FAIL start_err_set: got %b want 1", start_err); else passed++;
    send_bits(24'h5A5A5A, 24'h0F0F0F, 10, 14, 2'b11);
    wait_frame(ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || beat_q.size() !== 2) $display("FAIL start_err_count: got %0d want 2", beat_q.size()); else passed++;
    total++; if (beat_q[0] !== 32'h405A5A5A) $display("FAIL start_err_b0: got %h want 405a5a5a", beat_q[0]); else passed++;
    total++; if (beat_q[1] !== 32'h480F0F0F || last_q[1] !== 1'b1)
      $display("FAIL start_err_b1: got %h/%b want 480f0f0f/1", beat_q[1], last_q[1]); else passed++;
    pulse_clear();
    @(negedge clk);
    total++; if (start_err !== 1'b0) $display("FAIL start_err_clear: got %b want 0", start_err); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_start(4'd1);
    send_bits(24'hC3C3C3, 24'h3C3C3C, 0, 10, 2'b11);
    pulse_start(4'd1);
    @(negedge clk);
    total++; if (start_err !== 1'b1 || busy !== 1'b1)
      $display("FAIL rmid_pre: got %b%b want 11", start_err, busy); else passed++;
    #2; reset = 1'b1; #1;
    total++; if ({axis.m_axis_tvalid, axis.m_axis_tlast, busy, frame_done, extra_edge_err, start_err} !== 6'b0 ||
                 axis.m_axis_tdata !== 32'h0)
      $display("FAIL rmid_outputs: got %b/%h want 000000/0",
               {axis.m_axis_tvalid, axis.m_axis_tlast, busy, frame_done, extra_edge_err, start_err},
               axis.m_axis_tdata); else passed++;
    scko = 2'b00;
    repeat (2) @(posedge clk); #1; reset = 1'b0;
    clear_log();
    pulse_start(4'd1);
    send_bits(24'hFFFFFF, 24'hFFFFFF, 0, 24, 2'b11);
    wait_frame(ok);
    repeat (2) @(negedge clk);
    total++; if (!ok || beat_q[0] !== 32'h00FFFFFF) $display("FAIL rmid_b0: got %h want 00ffffff", beat_q[0]); else passed++;
    total++; if (beat_q[1] !== 32'h08FFFFFF) $display("FAIL rmid_b1: got %h want 08ffffff", beat_q[1]); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [3:0] fc;
    for (int i = 0; i < 16; i++) begin
      clear_log();
      fc = 4'((i + 1) % 16);
      pulse_start(4'd1);
      send_bits(24'h000100 + 24'(i), 24'h000200 + 24'(i), 0, 24, 2'b11);
      wait_frame(ok);
      repeat (2) @(negedge clk);
      total++; if (!ok || beat_q[0][31:28] !== fc)
        $display("FAIL b2b_fcnt%0d: got %h want %h", i, beat_q[0][31:28], fc); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_stall();
    test_extra_edge();
    test_start_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
